// File: rtl/modsimrand_pkg.sv
// Shared constants and types for the lagged-Fibonacci PN stream x[n] = x[n-55] + x[n-24] mod 2^32.
// Latency: n/a (package only).
// Backpressure: n/a.
package modsimrand_pkg;

    localparam int WORD_W    = 32;
    localparam int LAG_LONG  = 55;
    localparam int LAG_SHORT = 24;
    // Tap indices into the history, where hist[0] is the newest word.
    localparam int TAP_LONG  = LAG_LONG - 1;   // 54
    localparam int TAP_SHORT = LAG_SHORT - 1;  // 23

    // Word the generator emits while its register file is still at its reset value.
    localparam logic [WORD_W-1:0] RESET_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        FILL   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    function automatic logic [5:0] popcnt32(input logic [WORD_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < WORD_W; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/modsimrand_hist.sv
// 55-deep x 32-bit history shift register mirroring the PN generator's register file.
// Latency: shifted word visible on the taps one cycle after shift_en_i.
// Backpressure: none; shift_en_i simply freezes the contents.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all entries)
//   shift_en_i      shift shift_dat_i into entry 0, older entries move down by one
//   shift_dat_i     word to insert as the newest entry
//   tap_long_o      entry 54 (the x[n-55] term)
//   tap_short_o     entry 23 (the x[n-24] term)
module modsimrand_hist
    import modsimrand_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en_i,
    input  logic [WORD_W-1:0] shift_dat_i,
    output logic [WORD_W-1:0] tap_long_o,
    output logic [WORD_W-1:0] tap_short_o
);

    logic [WORD_W-1:0] hist_q [LAG_LONG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAG_LONG; i++) begin
                hist_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            hist_q[0] <= shift_dat_i;
            for (int i = 1; i < LAG_LONG; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    assign tap_long_o  = hist_q[TAP_LONG];
    assign tap_short_o = hist_q[TAP_SHORT];

endmodule

// File: rtl/modsimrand_chk.sv
// Receive-side PN checker: self-syncs on 55 words, then predicts and compares each accepted word.
// Latency: err_flag and counters reflect a sampled word one cycle later; locked follows the state register.
// Backpressure: none; clk_en qualifies samples, no stall output.
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clk_en       din sampled only when high
//   din          received PN word
//   cnt_clr      synchronous counter clear, acts regardless of clk_en
//   locked       high while in LOCKED
//   err_flag     registered one-cycle pulse for a mismatched word in LOCKED
//   err_cnt      saturating mismatch count since lock entry / clear
//   word_cnt     saturating compared-word count since lock entry / clear
//   biterr_cnt   (only with MODSIMRAND_CHK_BITERR_EN) saturating sum of mismatched bits
module modsimrand_chk
    import modsimrand_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int LOSS_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [WORD_W-1:0] din,
    input  logic              cnt_clr,
    output logic              locked,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
`ifdef MODSIMRAND_CHK_BITERR_EN
    ,
    output logic [CNT_W-1:0]  biterr_cnt
`endif
);

    localparam logic [5:0]       FILL_LAST = 6'(LAG_LONG - 1);
    localparam logic [7:0]       MISS_LAST = 8'(LOSS_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    chk_state_t        state_q, state_d;
    logic [5:0]        fill_q, fill_d;
    logic [7:0]        miss_q, miss_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  word_q, word_d;
    logic              flag_q, flag_d;

    logic [WORD_W-1:0] tap_long, tap_short, pred, shift_dat;
    logic              mismatch, lock_entry, compare_en;

    assign pred       = tap_long + tap_short;
    assign mismatch   = (din != pred);
    assign lock_entry = clk_en && (state_q == FILL) && (fill_q == FILL_LAST);
    assign compare_en = clk_en && (state_q == LOCKED);

    // While locked, shifting pred is always right: on a match it equals din, and on a
    // mismatch it keeps the flywheel running so a bad word never reaches the taps.
    assign shift_dat = (state_q == LOCKED) ? pred : din;

    modsimrand_hist u_hist (
        .clk         (clk),
        .rst_n       (reset),
        .shift_en_i  (clk_en),
        .shift_dat_i (shift_dat),
        .tap_long_o  (tap_long),
        .tap_short_o (tap_short)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        miss_d  = miss_q;
        err_d   = err_q;
        word_d  = word_q;
        flag_d  = 1'b0;

        if (clk_en) begin
            case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = LOCKED;
                        fill_d  = '0;
                        miss_d  = '0;
                        err_d   = '0;
                        word_d  = '0;
                    end else begin
                        fill_d = fill_q + 6'd1;
                    end
                end
                LOCKED: begin
                    if (word_q != CNT_MAX) word_d = word_q + CNT_ONE;
                    if (mismatch) begin
                        flag_d = 1'b1;
                        if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
                        if (miss_q == MISS_LAST) begin
                            // Counters deliberately hold so the loss event stays visible.
                            state_d = FILL;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            endcase
        end

        if (cnt_clr) begin
            err_d  = '0;
            word_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            fill_q  <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            word_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            word_q  <= word_d;
            flag_q  <= flag_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign err_flag = flag_q;
    assign err_cnt  = err_q;
    assign word_cnt = word_q;

`ifdef MODSIMRAND_CHK_BITERR_EN
    logic [CNT_W-1:0] biterr_q, biterr_d;
    logic [CNT_W:0]   biterr_sum;

    always_comb begin
        // One extra bit catches the carry so the add can saturate.
        biterr_sum = {1'b0, biterr_q} + (CNT_W+1)'(popcnt32(din ^ pred));
        biterr_d   = biterr_q;
        if (lock_entry) begin
            biterr_d = '0;
        end else if (compare_en && mismatch) begin
            biterr_d = biterr_sum[CNT_W] ? CNT_MAX : biterr_sum[CNT_W-1:0];
        end
        if (cnt_clr) biterr_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) biterr_q <= '0;
        else        biterr_q <= biterr_d;
    end

    assign biterr_cnt = biterr_q;
`else
    logic unused_feat;
    assign unused_feat = lock_entry & compare_en;
`endif

endmodule

// File: tb/tb_modsimrand_chk.sv
// Scoreboard bench for modsimrand_chk: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_modsimrand_chk;
    import modsimrand_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [31:0] din;
    logic        cnt_clr;
    logic        locked, err_flag;
    logic [31:0] err_cnt, word_cnt;
`ifdef MODSIMRAND_CHK_BITERR_EN
    logic [31:0] biterr_cnt;
`endif

    always #5 clk = ~clk;

    modsimrand_chk #(.CNT_W(32), .LOSS_THRESH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .din        (din),
        .cnt_clr    (cnt_clr),
        .locked     (locked),
        .err_flag   (err_flag),
        .err_cnt    (err_cnt),
        .word_cnt   (word_cnt)
`ifdef MODSIMRAND_CHK_BITERR_EN
        ,
        .biterr_cnt (biterr_cnt)
`endif
    );

    typedef struct packed {
        logic        lk;
        logic        fl;
        logic [31:0] ec;
        logic [31:0] wc;
        logic [31:0] bc;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e, mon_a;
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference PN stream: x[n] = 0xFFFFFFFF for n < 55, else x[n-55] + x[n-24].
    logic [31:0] xs[$];

    // Expected checker state, advanced per driven cycle.
    logic        m_lk = 1'b0;
    logic        m_fl = 1'b0;
    int          m_ec = 0, m_wc = 0, m_bc = 0, m_fill = 0, m_miss = 0;

    function automatic resp_t actual();
        resp_t r;
        r.lk = locked;
        r.fl = err_flag;
        r.ec = err_cnt;
        r.wc = word_cnt;
`ifdef MODSIMRAND_CHK_BITERR_EN
        r.bc = biterr_cnt;
`else
        r.bc = '0;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = actual();
            n_chk++;
            if (mon_a === mon_e) n_pass++;
            else $display("FAIL scoreboard @%0t: got lk=%0b fl=%0b ec=%0d wc=%0d bc=%0d, expected lk=%0b fl=%0b ec=%0d wc=%0d bc=%0d",
                          $time, mon_a.lk, mon_a.fl, mon_a.ec, mon_a.wc, mon_a.bc,
                          mon_e.lk, mon_e.fl, mon_e.ec, mon_e.wc, mon_e.bc);
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic gen(output logic [31:0] w);
        int n;
        n = xs.size();
        w = (n < 55) ? RESET_WORD : xs[n-55] + xs[n-24];
        xs.push_back(w);
    endtask

    // One driven cycle: d is what the link delivers, truth is the word the generator sent.
    task automatic step(input logic en, input logic [31:0] d, input logic [31:0] truth, input logic clr);
        resp_t r;
        @(negedge clk);
        clk_en  = en;
        din     = d;
        cnt_clr = clr;
        m_fl    = 1'b0;
        if (en) begin
            if (!m_lk) begin
                m_fill++;
                if (m_fill == 55) begin
                    m_lk = 1'b1; m_fill = 0; m_miss = 0; m_ec = 0; m_wc = 0; m_bc = 0;
                end
            end else begin
                m_wc++;
                if (d !== truth) begin
                    m_fl = 1'b1;
                    m_ec++;
`ifdef MODSIMRAND_CHK_BITERR_EN
                    m_bc += $countones(d ^ truth);
`endif
                    m_miss++;
                    if (m_miss == 8) begin
                        m_lk = 1'b0; m_fill = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) begin
            m_ec = 0; m_wc = 0; m_bc = 0;
        end
        @(posedge clk);
        r.lk = m_lk; r.fl = m_fl; r.ec = m_ec; r.wc = m_wc; r.bc = m_bc;
        exp_q.push_back(r);
    endtask

    task automatic send(input logic [31:0] flip, input logic zero, input logic clr);
        logic [31:0] w;
        gen(w);
        step(1'b1, zero ? 32'h0 : (w ^ flip), w, clr);
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) send(32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic clr);
        step(1'b0, $urandom, 32'h0, clr);
    endtask

    // Stop driving, let the monitor drain the last response, then sit just after the negedge.
    task automatic settle();
        @(negedge clk);
        clk_en  = 1'b0;
        cnt_clr = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_lk = 1'b0; m_fl = 1'b0; m_ec = 0; m_wc = 0; m_bc = 0; m_fill = 0; m_miss = 0;
    endtask

    initial begin
        reset = 1'b0; clk_en = 1'b0; din = '0; cnt_clr = 1'b0;
        #12;
        check_val("reset_locked",   {31'b0, locked},   32'h0);
        check_val("reset_err_flag", {31'b0, err_flag}, 32'h0);
        check_val("reset_err_cnt",  err_cnt,           32'h0);
        check_val("reset_word_cnt", word_cnt,          32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Acquire from a generator leaving reset: 55 x FFFFFFFF, then 24 x FFFFFFFE, then FFFFFFFD.
        send_good(54);
        settle();
        check_val("fill_not_locked_54", {31'b0, locked}, 32'h0);
        send_good(1);
        settle();
        check_val("locked_after_55", {31'b0, locked}, 32'h1);
        send_good(25);
        settle();
        check_val("lock_word_cnt", word_cnt, 32'd25);
        check_val("lock_err_cnt",  err_cnt,  32'd0);

        // Single corrupted word, then 100 clean words riding on the flywheel.
        send(32'h1, 1'b0, 1'b0);
        send_good(100);
        settle();
        check_val("single_err_cnt",  err_cnt,           32'd1);
        check_val("single_locked",   {31'b0, locked},   32'h1);
        check_val("single_word_cnt", word_cnt,          32'd126);

        // clk_en held low with random din, then resume.
        for (int i = 0; i < 20; i++) idle(1'b0);
        send_good(5);
        settle();
        check_val("gate_word_cnt", word_cnt, 32'd131);
        check_val("gate_err_cnt",  err_cnt,  32'd1);

        // Clear coincident with a mismatch: clear wins, flag still pulses.
        send(32'h2, 1'b0, 1'b1);
        settle();
        check_val("clr_err_cnt",  err_cnt,           32'd0);
        check_val("clr_err_flag", {31'b0, err_flag}, 32'h1);
        send_good(2);

`ifdef MODSIMRAND_CHK_BITERR_EN
        idle(1'b1);
        send(32'h0000_000F, 1'b0, 1'b0);
        settle();
        check_val("biterr_cnt_4", biterr_cnt, 32'd4);
        send_good(2);
`endif

        // Loss of lock: 8 consecutive zero words.
        idle(1'b1);
        for (int i = 0; i < 8; i++) send(32'h0, 1'b1, 1'b0);
        settle();
        check_val("loss_err_cnt", err_cnt,         32'd8);
        check_val("loss_locked",  {31'b0, locked}, 32'h0);
        send_good(54);
        settle();
        check_val("relock_not_yet", {31'b0, locked}, 32'h0);
        send_good(1);
        settle();
        check_val("relock_locked",   {31'b0, locked}, 32'h1);
        check_val("relock_word_cnt", word_cnt,        32'd0);

        // Async reset mid-LOCKED with nonzero counters and a live error pulse.
        send_good(3);
        send(32'h10, 1'b0, 1'b0);
        settle();
        reset = 1'b0;
        model_reset();
        #1;
        check_val("areset_locked",   {31'b0, locked},   32'h0);
        check_val("areset_err_flag", {31'b0, err_flag}, 32'h0);
        check_val("areset_err_cnt",  err_cnt,           32'h0);
        check_val("areset_word_cnt", word_cnt,          32'h0);
        @(negedge clk);
        reset = 1'b1;
        send_good(55);
        send_good(3);
        settle();
        check_val("reacq_locked",   {31'b0, locked}, 32'h1);
        check_val("reacq_word_cnt", word_cnt,        32'd3);

        settle();
        check_val("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
